alu_sequencer: RTL and testbench

Program sequencer for the 4-bit ALU datapath (`operador`-style unit, opcode in `instr[7:5]`, operands A/B, registered result). Holds a small program memory and a 4-entry operand register file. On `start`, it fetches each instruction, drives the ALU's instruction and operand inputs, and waits the ALU latency. It then writes the result back into the register file or presents it on the output port. It sits between the host/test interface and the ALU, and is the only driver of the ALU's inputs.

---
 rtl/alu_sequencer.sv | 153 +++++++++++++++
 tb/tb_alu_sequencer.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_sequencer.sv
// Program sequencer for a small ALU: fetches instructions from a local program memory,
// issues operands from a 4-entry register file, waits the ALU latency and retires the result.
module alu_sequencer #(
  parameter int WIDTH   = 4,
  parameter int DEPTH   = 8,
  parameter int ALU_LAT = 2,
  localparam int AW     = $clog2(DEPTH),
  localparam int CW     = $clog2(ALU_LAT + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             prog_we,
  input  logic [AW-1:0]    prog_addr,
  input  logic [7:0]       prog_data,
  input  logic             reg_we,
  input  logic [1:0]       reg_addr,
  input  logic [WIDTH-1:0] reg_data,
  input  logic [1:0]       rd_addr,
  output logic [WIDTH-1:0] rd_data,
  input  logic             start,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic [7:0]       alu_instr,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_result,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid
);

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_ISSUE, S_WAIT, S_WRITE, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [AW-1:0]    pc_q, pc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [7:0]       ir_q, ir_d;
  logic [7:0]       mem_q [DEPTH];
  logic [7:0]       mem_d [DEPTH];
  logic [WIDTH-1:0] regs_q [4];
  logic [WIDTH-1:0] regs_d [4];
  logic [7:0]       alu_instr_q, alu_instr_d;
  logic [WIDTH-1:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;
  logic             aborting;

  assign aborting = abort && (state_q != S_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (aborting) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:  if (start) state_d = S_FETCH;
        S_FETCH: state_d = S_ISSUE;
        S_ISSUE: state_d = S_WAIT;
        S_WAIT:  if (cnt_q == '0) state_d = S_WRITE;
        S_WRITE: state_d = (ir_q[0] || pc_q == AW'(DEPTH - 1)) ? S_DONE : S_FETCH;
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    busy = (state_q != S_IDLE);
    done = (state_q == S_DONE) && !abort;
  end

  always_comb begin
    pc_d        = pc_q;
    cnt_d       = cnt_q;
    ir_d        = ir_q;
    mem_d       = mem_q;
    regs_d      = regs_q;
    alu_instr_d = alu_instr_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    out_data_d  = out_data_q;
    out_valid_d = 1'b0;
    if (aborting) begin
      // Abort drops any retiring result and rewinds the program.
      pc_d = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (prog_we) mem_d[prog_addr] = prog_data;
          if (reg_we)  regs_d[reg_addr] = reg_data;
          if (start)   pc_d = '0;
        end
        S_FETCH: ir_d = mem_q[pc_q];
        S_ISSUE: begin
          alu_instr_d = ir_q;
          alu_a_d     = regs_q[ir_q[4:3]];
          alu_b_d     = regs_q[ir_q[2:1]];
          cnt_d       = CW'(ALU_LAT - 1);
        end
        S_WAIT:  if (cnt_q != '0) cnt_d = cnt_q - CW'(1);
        S_WRITE: begin
          if (ir_q[7:5] == 3'd7) begin
            out_data_d  = alu_result;
            out_valid_d = 1'b1;
          end else begin
            regs_d[ir_q[4:3]] = alu_result;
          end
          pc_d = pc_q + AW'(1);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q        <= '0;
      cnt_q       <= '0;
      ir_q        <= '0;
      alu_instr_q <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      for (int i = 0; i < 4; i++) regs_q[i] <= '0;
    end else begin
      pc_q        <= pc_d;
      cnt_q       <= cnt_d;
      ir_q        <= ir_d;
      alu_instr_q <= alu_instr_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      mem_q       <= mem_d;
      regs_q      <= regs_d;
    end
  end

  assign rd_data   = regs_q[rd_addr];
  assign alu_instr = alu_instr_q;
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: pipelined ALU model, instruction-level reference model,
// single-instruction vector table, hand-timed corner cases and random programs.
module tb_alu_sequencer;
  localparam int WIDTH = 4, DEPTH = 8, ALU_LAT = 2, AW = 3;

  logic clk = 0, rst = 1;
  logic prog_we = 0, reg_we = 0, start = 0, abort = 0;
  logic [AW-1:0] prog_addr = '0;
  logic [7:0] prog_data = '0;
  logic [1:0] reg_addr = '0, rd_addr = '0;
  logic [WIDTH-1:0] reg_data = '0;
  logic [WIDTH-1:0] rd_data, alu_a, alu_b, alu_result, out_data;
  logic [7:0] alu_instr;
  logic busy, done, out_valid;

  int checks = 0, errors = 0;

  alu_sequencer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ALU_LAT(ALU_LAT)) dut (
    .clk(clk), .rst(rst), .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
    .reg_we(reg_we), .reg_addr(reg_addr), .reg_data(reg_data), .rd_addr(rd_addr),
    .rd_data(rd_data), .start(start), .abort(abort), .busy(busy), .done(done),
    .alu_instr(alu_instr), .alu_a(alu_a), .alu_b(alu_b), .alu_result(alu_result),
    .out_data(out_data), .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  // Test ALU: op0 add, op1 sub, op2 and, op3 or, op4 xor, op5 not A, op6 pass B, op7 pass A
  function automatic logic [3:0] alu_f(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
    case (op)
      3'd0: return 4'(a + b);
      3'd1: return 4'(a - b);
      3'd2: return a & b;
      3'd3: return a | b;
      3'd4: return a ^ b;
      3'd5: return ~a;
      3'd6: return b;
      default: return a;
    endcase
  endfunction

  logic [3:0] pipe [ALU_LAT];
  always_ff @(posedge clk) begin
    pipe[0] <= alu_f(alu_instr[7:5], alu_a, alu_b);
    for (int i = 1; i < ALU_LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign alu_result = pipe[ALU_LAT-1];

  // Reference model state
  logic [7:0] m_mem [DEPTH];
  logic [3:0] m_regs [4];
  logic [3:0] m_out;
  int m_n, m_ov;

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) m_mem[i] = 8'h00;
    for (int i = 0; i < 4; i++) m_regs[i] = 4'h0;
    m_out = 4'h0;
  endtask

  task automatic model_run();
    logic [7:0] ins;
    logic [3:0] r;
    m_n = 0; m_ov = 0;
    for (int pc = 0; pc < DEPTH; pc++) begin
      ins = m_mem[pc];
      r = alu_f(ins[7:5], m_regs[ins[4:3]], m_regs[ins[2:1]]);
      if (ins[7:5] == 3'd7) begin m_out = r; m_ov++; end
      else m_regs[ins[4:3]] = r;
      m_n++;
      if (ins[0]) break;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic write_mem(input logic [AW-1:0] a, input logic [7:0] d);
    prog_we = 1; prog_addr = a; prog_data = d;
    @(posedge clk); #1;
    prog_we = 0;
    m_mem[a] = d;
  endtask

  task automatic write_reg(input logic [1:0] a, input logic [3:0] d);
    reg_we = 1; reg_addr = a; reg_data = d;
    @(posedge clk); #1;
    reg_we = 0;
    m_regs[a] = d;
  endtask

  task automatic chk_regs(input string tag);
    for (int i = 0; i < 4; i++) begin
      rd_addr = 2'(i); #1;
      chk($sformatf("%s r%0d", tag, i), rd_data, m_regs[i]);
    end
  endtask

  task automatic run_prog(input string tag, input bit poke, input bit co_we,
                          input logic [AW-1:0] co_addr, input logic [7:0] co_data);
    int nb, nd, nov, guard;
    nb = 0; nd = 0; nov = 0; guard = 0;
    @(posedge clk); #1;
    start = 1;
    if (co_we) begin
      prog_we = 1; prog_addr = co_addr; prog_data = co_data; m_mem[co_addr] = co_data;
    end
    @(posedge clk); #1;
    start = 0; prog_we = 0;
    model_run();
    do begin
      @(negedge clk);
      guard++;
      nb += int'(busy); nd += int'(done); nov += int'(out_valid);
      if (poke && busy) begin
        start = 1; prog_we = 1; reg_we = 1;
        prog_addr = AW'($urandom_range(0, DEPTH-1)); prog_data = 8'($urandom);
        reg_addr = 2'($urandom_range(0, 3)); reg_data = 4'($urandom);
      end else begin
        start = 0; prog_we = 0; reg_we = 0;
      end
    end while (busy && guard < 400);
    chk({tag, " timeout"}, guard < 400, 1);
    chk({tag, " busy cycles"}, nb, 5 * m_n + 1);
    chk({tag, " done pulses"}, nd, 1);
    chk({tag, " out_valid pulses"}, nov, m_ov);
    chk({tag, " out_data"}, out_data, m_out);
    chk_regs(tag);
    $display("run %s: instrs=%0d busy=%0d done=%0d ov=%0d out=%0h", tag, m_n, nb, nd, nov, out_data);
  endtask

  typedef struct {
    logic [2:0] op; logic [1:0] ra, rb; logic [3:0] a, b, exp;
  } vec_t;
  vec_t vecs [9];

  initial begin
    logic [7:0] prog [DEPTH];
    logic [3:0] snap [4];
    int ndone;

    vecs[0] = '{3'd0, 2'd0, 2'd1, 4'h3, 4'h5, 4'h8};
    vecs[1] = '{3'd0, 2'd2, 2'd3, 4'h9, 4'h9, 4'h2};
    vecs[2] = '{3'd1, 2'd1, 2'd2, 4'h3, 4'h5, 4'hE};
    vecs[3] = '{3'd2, 2'd3, 2'd0, 4'hC, 4'hA, 4'h8};
    vecs[4] = '{3'd3, 2'd0, 2'd2, 4'hC, 4'hA, 4'hE};
    vecs[5] = '{3'd4, 2'd1, 2'd3, 4'hC, 4'hA, 4'h6};
    vecs[6] = '{3'd5, 2'd2, 2'd0, 4'hC, 4'hA, 4'h3};
    vecs[7] = '{3'd6, 2'd3, 2'd1, 4'hC, 4'hA, 4'hA};
    vecs[8] = '{3'd7, 2'd1, 2'd0, 4'hA, 4'h3, 4'hA};

    model_clear();
    repeat (3) @(posedge clk);
    #1;
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset alu_instr", alu_instr, 0);
    chk("reset alu_a", alu_a, 0);
    chk("reset alu_b", alu_b, 0);
    chk("reset out_data", out_data, 0);
    chk("reset out_valid", out_valid, 0);
    chk_regs("reset");
    rst = 0;

    // Single-instruction timing: add r0,r1 with halt
    write_reg(0, 4'h3); write_reg(1, 4'h5); write_mem(0, 8'h03);
    rd_addr = 0;
    @(posedge clk); #1; start = 1;
    @(posedge clk); #1; start = 0;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      if (k == 1) chk("t1 busy", busy, 1);
      if (k == 3) begin
        chk("t3 alu_instr", alu_instr, 8'h03);
        chk("t3 alu_a", alu_a, 4'h3);
        chk("t3 alu_b", alu_b, 4'h5);
      end
      if (k == 5) chk("t5 r0 old", rd_data, 4'h3);
      if (k == 6) begin
        chk("t6 r0 new", rd_data, 4'h8);
        chk("t6 done", done, 1);
      end
      if (k == 7) begin
        chk("t7 busy", busy, 0);
        chk("t7 done", done, 0);
      end
    end
    model_run();
    $display("timing run: r0=%0h", rd_data);

    // Vector table, one halting instruction each
    for (int i = 0; i < 9; i++) begin
      write_reg(vecs[i].ra, vecs[i].a);
      write_reg(vecs[i].rb, vecs[i].b);
      write_mem(0, {vecs[i].op, vecs[i].ra, vecs[i].rb, 1'b1});
      run_prog($sformatf("vec%0d", i), 0, 0, '0, '0);
      rd_addr = vecs[i].ra; #1;
      if (vecs[i].op == 3'd7) chk($sformatf("vec%0d out", i), out_data, vecs[i].exp);
      else chk($sformatf("vec%0d dst", i), rd_data, vecs[i].exp);
    end

    // op7 keeps register file intact
    write_reg(1, 4'hA); write_mem(0, 8'hE9);
    for (int i = 0; i < 4; i++) snap[i] = m_regs[i];
    run_prog("op7", 0, 0, '0, '0);
    chk("op7 out_data", out_data, 4'hA);
    for (int i = 0; i < 4; i++) begin
      rd_addr = 2'(i); #1;
      chk($sformatf("op7 r%0d kept", i), rd_data, snap[i]);
    end

    // Abort during WAIT of instruction 0
    write_reg(0, 4'h3); write_reg(1, 4'h5); write_mem(0, 8'h03);
    @(posedge clk); #1; start = 1;
    @(posedge clk); #1; start = 0;
    @(posedge clk);
    @(posedge clk); #1; abort = 1;
    @(posedge clk); #1; abort = 0;
    @(negedge clk);
    chk("abort busy", busy, 0);
    ndone = 0;
    repeat (10) begin @(negedge clk); ndone += int'(done); end
    chk("abort no done", ndone, 0);
    chk_regs("abort");
    $display("abort run: busy=%0d", busy);
    run_prog("after abort", 0, 0, '0, '0);
    chk("after abort r0", m_regs[0], 4'h8);

    // Busy-time writes and starts are ignored
    for (int i = 0; i < DEPTH; i++) prog[i] = {3'($urandom_range(0, 6)), 2'($urandom), 2'($urandom), 1'b0};
    prog[3][0] = 1'b1;
    for (int i = 0; i < DEPTH; i++) write_mem(AW'(i), prog[i]);
    for (int i = 0; i < 4; i++) begin snap[i] = 4'($urandom); write_reg(2'(i), snap[i]); end
    run_prog("undisturbed", 0, 0, '0, '0);
    for (int i = 0; i < 4; i++) write_reg(2'(i), snap[i]);
    run_prog("disturbed", 1, 0, '0, '0);

    // Reset during WRITE
    write_reg(0, 4'h3); write_reg(1, 4'h5); write_mem(0, 8'h03);
    rd_addr = 0;
    @(posedge clk); #1; start = 1;
    @(posedge clk); #1; start = 0;
    repeat (4) @(posedge clk);
    #2 rst = 1;
    #1;
    chk("rst busy", busy, 0);
    chk("rst done", done, 0);
    chk("rst alu_instr", alu_instr, 0);
    chk("rst alu_a", alu_a, 0);
    chk("rst alu_b", alu_b, 0);
    chk("rst out_data", out_data, 0);
    chk("rst out_valid", out_valid, 0);
    chk("rst r0", rd_data, 0);
    @(posedge clk); #1; rst = 0;
    model_clear();
    $display("reset during write: r0=%0h", rd_data);

    // Cleared memory runs eight add r0,r0 without halt
    write_reg(0, 4'h1);
    run_prog("eight doublings", 0, 0, '0, '0);
    chk("eight r0", m_regs[0], 4'h0);
    chk("eight instrs", m_n, 8);

    // Random programs; mem[0] written in the start cycle
    for (int r = 0; r < 12; r++) begin
      for (int i = 1; i < DEPTH; i++)
        write_mem(AW'(i), {3'($urandom), 2'($urandom), 2'($urandom), 1'($urandom_range(0, 3) == 0)});
      for (int i = 0; i < 4; i++) write_reg(2'(i), 4'($urandom));
      run_prog($sformatf("rand%0d", r), 0, 1, '0,
               {3'($urandom), 2'($urandom), 2'($urandom), 1'($urandom_range(0, 5) == 0)});
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
